// File: rtl/s349_pkg.sv
// Shared definitions for the s349 sequential multiplier family.
// Contents:
//   state_t       - controller state encoding (IDLE / RUN)
//   DEFAULT_WIDTH - default operand width
//   ct_w()        - width of the iteration counter for a given operand width
package s349_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter must be able to represent 0..WIDTH, so it is clog2(WIDTH+1) bits.
  function automatic int ct_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/s349_mult_seq_if.sv
// Operand/result bundle for s349_mult_seq.
// Signals:
//   start - start request (master -> slave)
//   ax    - multiplicand, WIDTH bits (master -> slave)
//   bx    - multiplier, WIDTH bits (master -> slave)
//   ready - idle and able to accept start (slave -> master)
//   done  - one-cycle pulse, p has just been updated (slave -> master)
//   p     - product register, 2*WIDTH bits (slave -> master)
//   ct    - current iteration count (slave -> master)
interface s349_mult_seq_if
  import s349_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  localparam int CW = ct_w(WIDTH);

  logic                 start;
  logic [WIDTH-1:0]     ax;
  logic [WIDTH-1:0]     bx;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   p;
  logic [CW-1:0]        ct;

  modport master (
    output start, ax, bx,
    input  ready, done, p, ct
  );

  modport slave (
    input  start, ax, bx,
    output ready, done, p, ct
  );

endinterface

// File: rtl/s349_mult_dp.sv
// Shift-add datapath: multiplicand, accumulator and multiplier registers plus
// the adder/shifter for one iteration.
// Ports:
//   ck        - rising-edge clock
//   reset_n   - asynchronous active-low reset, clears all registers
//   load      - capture ax/bx, clear the accumulator
//   step      - perform one shift-add iteration
//   ax, bx    - operands (WIDTH bits)
//   prod_next - {acc, mr} as it will be after the current iteration (2*WIDTH bits)
module s349_mult_dp #(
  parameter int WIDTH = 4
) (
  input  logic               ck,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   ax,
  input  logic [WIDTH-1:0]   bx,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mr_reg;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mr_next;

  // The extra sum bit keeps the carry; after the right shift it becomes the
  // accumulator MSB, and the accumulator LSB slides into the multiplier MSB.
  assign sum       = {1'b0, acc_reg} + (mr_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_next  = sum[WIDTH:1];
  assign mr_next   = {sum[0], mr_reg[WIDTH-1:1]};
  assign prod_next = {acc_next, mr_next};

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg <= '0;
      acc_reg   <= '0;
      mr_reg    <= '0;
    end else if (load) begin
      mcand_reg <= ax;
      acc_reg   <= '0;
      mr_reg    <= bx;
    end else if (step) begin
      acc_reg   <= acc_next;
      mr_reg    <= mr_next;
    end
  end

endmodule

// File: rtl/s349_mult_seq.sv
// Sequential unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product
// in WIDTH iterations, with a start/ready/done handshake.
// Ports:
//   ck      - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - s349_mult_seq_if slave: start, ax, bx in; ready, done, p, ct out
module s349_mult_seq
  import s349_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            ck,
  input  logic            reset_n,
  s349_mult_seq_if.slave  bus
);

  localparam int CW = ct_w(WIDTH);
  localparam logic [CW-1:0] CT_LAST = CW'(WIDTH - 1);

  state_t             state_reg;
  logic [CW-1:0]      ct_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic               done_reg;

  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] prod_next;

  // Start is only honoured when idle; requests during RUN are dropped.
  assign load = (state_reg == IDLE) && bus.start;
  assign step = (state_reg == RUN);

  s349_mult_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .ck        (ck),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .ax        (bus.ax),
    .bx        (bus.bx),
    .prod_next (prod_next)
  );

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ct_reg    <= '0;
      p_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            ct_reg    <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (ct_reg == CT_LAST) begin
            // Final iteration: the shifted value is the complete product.
            p_reg     <= prod_next;
            done_reg  <= 1'b1;
            ct_reg    <= '0;
            state_reg <= IDLE;
          end else begin
            ct_reg <= ct_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ct_reg    <= '0;
        end
      endcase
    end
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.done  = done_reg;
  assign bus.p     = p_reg;
  assign bus.ct    = ct_reg;

endmodule
